udp_decoder: RTL and testbench
==============================

Name: udp_decoder

Overview:
- Downstream stage of the IP decoder; consumes its 32-bit payload word stream (data_out/wr_en/fin/ok) and the IP source/destination addresses.
- Parses the 8-byte UDP header into registered fields, forwards the UDP payload one word per accepted input word with per-byte valid marks, and flags length and protocol errors.
- Checksum verification is compile-time optional.

Parameters:
- MAX_LEN, 16'd1472, largest accepted UDP length in bytes; larger values flag an error.

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_data  in  32  IP payload word; byte 0 in [31:24]
- in_valid  in  1  in_data valid this cycle (IP decoder wr_en); gaps allowed
- in_last  in  1  with in_valid: final IP payload word (IP decoder fin)
- in_ok  in  1  IP header accepted; sampled with first in_valid of a datagram
- in_protocol  in  8  IP protocol field; stable for the datagram
- in_src_ip  in  32  IP source address; stable for the datagram
- in_dest_ip  in  32  IP destination address; stable for the datagram
- src_port  out  16  UDP source port
- dest_port  out  16  UDP destination port
- udp_length  out  16  UDP length field, header included
- udp_chksum  out  16  UDP checksum field as received
- out_data  out  32  payload word
- out_valid  out  1  out_data valid
- out_keep  out  4  valid bytes in out_data; bit 3 = [31:24]
- out_last  out  1  final payload word
- fin  out  1  one-cycle pulse: datagram complete (good or bad)
- ok  out  1  with fin: datagram good; held until next datagram starts
- err  out  1  with fin: datagram bad; held until next datagram starts

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset asserted mid-datagram aborts immediately; no fin is produced.
- States: IDLE, HDR1, PAYLOAD, DRAIN, DONE.
- IDLE: on in_valid, latch {src_port,dest_port}=in_data; clear ok/err; go to HDR1.
  - in_ok=0 or in_protocol!=17: set bad flag, go to DRAIN.
- HDR1: on in_valid, latch {udp_length,udp_chksum}=in_data; remaining = udp_length-8.
  - udp_length<8 or udp_length>MAX_LEN: bad, DRAIN.
  - remaining=0: DONE.
  - Otherwise: PAYLOAD.
- Early end: in_last in IDLE or HDR1 means truncated. Set bad and go straight to DONE.
- PAYLOAD: each in_valid word is registered to out_data/out_valid with 1-cycle latency.
  - remaining -= min(4, remaining).
  - out_keep = 4'b1111 if remaining>=4, else MSB-aligned mask (3→1110, 2→1100, 1→1000).
  - When remaining reaches 0: out_last=1 on that word. If in_last is not also set, go to DRAIN (IP padding, ignored); otherwise go to DONE.
  - in_last while remaining>min(4,remaining): that word is still output with out_last=1; set bad; go to DONE.
- DRAIN: discard in_valid words until in_last, then DONE. No out_valid is produced.
- DONE: one cycle later than the last accepted input word, fin=1 with either ok=1 or err=1 (never both). Next cycle go to IDLE.
- A new in_valid arriving in the same cycle as DONE is accepted as word 0 of the next datagram.
- Header fields hold until overwritten by the next datagram.

Optional Feature:
- UDP_CHKSUM_EN defined: a 16-bit one's-complement accumulator with end-around carry sums:
  - pseudo-header: in_src_ip, in_dest_ip, {8'h00,8'd17}, udp_length;
  - the UDP header;
  - all payload bytes up to udp_length, with an odd final byte zero-padded.
- At DONE, if udp_chksum!=0 and sum!=16'hFFFF, the datagram is bad (err). udp_chksum==0 means the checksum is skipped.
- UDP_CHKSUM_EN undefined: no accumulator; the checksum never affects ok/err.

Decomposition:
- Shared include udp_defs: state encodings, UDP_HDR_BYTES=8, IP_PROTO_UDP=8'd17.
- One sub-module, ones_comp_add16: combinational 16+16 end-around-carry adder. Instantiated twice (two halves of each word) only under UDP_CHKSUM_EN.

Test Plan:
- Basic datagram:
  - Stimulus: in_ok=1, protocol 17; words 1234_0050, 0013_0000, "Hell", "o Wo", "rld\0", in_last on word 5.
  - Required: src_port=1234, dest_port=0050, udp_length=0013; three out_valid words with keep 1111, 1111, 1110; out_last on the third; fin with ok=1.
- IP padding:
  - Stimulus: udp_length=000A, then two payload words with in_last on a third padding word.
  - Required: one out word with keep 1100 and out_last; padding dropped; fin one cycle after the padding word; ok=1.
- Truncation:
  - Stimulus: udp_length=0020, in_last on the first payload word.
  - Required: one out word with out_last; fin with err=1.
- Bad header:
  - Stimulus: udp_length=0004, or protocol 6, or in_ok=0.
  - Required: no out_valid; fin with err=1 after in_last.
- Reset abort:
  - Stimulus: reset low during PAYLOAD, then a clean basic datagram.
  - Required: outputs 0 during reset; no fin for the aborted datagram; second datagram ok=1.
- Checksum (UDP_CHKSUM_EN):
  - Stimulus: basic datagram with the correct checksum from the bench model; repeat with that checksum XOR 0001; repeat with checksum 0000.
  - Required: ok=1, then err=1, then ok=1.

Source files
------------

// File: rtl/udp_decoder_pkg.sv
// rtl/udp_decoder_pkg.sv - shared UDP decoder definitions: states, header constants, one's-complement add
// Contents: state_e (IDLE/HDR1/PAYLOAD/DRAIN/DONE), UDP_HDR_BYTES, IP_PROTO_UDP, ones_add().
package udp_decoder_pkg;

    localparam logic [15:0] UDP_HDR_BYTES = 16'd8;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR1    = 3'd1,
        S_PAYLOAD = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    // 16-bit one's-complement add; a single end-around fold is enough because
    // FFFF+FFFF = 1FFFE folds to FFFF without a second carry.
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/udp_decoder_ones_comp_add16.sv
// rtl/udp_decoder_ones_comp_add16.sv - combinational 16+16 one's-complement adder with end-around carry
// Ports: a_i, b_i (16-bit operands); sum_o (16-bit folded sum).
module ones_comp_add16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);

    logic [16:0] raw;

    assign raw   = {1'b0, a_i} + {1'b0, b_i};
    assign sum_o = raw[15:0] + {15'd0, raw[16]};

endmodule

// File: rtl/udp_decoder.sv
// rtl/udp_decoder.sv - UDP header parser / payload forwarder behind the IP decoder
// Optional macro: UDP_CHKSUM_EN enables pseudo-header + datagram checksum verification.
// Inputs : clk, reset (async active-low), in_data/in_valid/in_last word stream, in_ok,
//          in_protocol, in_src_ip, in_dest_ip.
// Outputs: src_port, dest_port, udp_length, udp_chksum (registered header fields),
//          out_data/out_valid/out_keep/out_last payload stream, fin pulse with ok/err status.
module udp_decoder
    import udp_decoder_pkg::*;
#(
    parameter logic [15:0] MAX_LEN = 16'd1472
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic        in_ok,
    input  logic [7:0]  in_protocol,
    input  logic [31:0] in_src_ip,
    input  logic [31:0] in_dest_ip,
    output logic [15:0] src_port,
    output logic [15:0] dest_port,
    output logic [15:0] udp_length,
    output logic [15:0] udp_chksum,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic [3:0]  out_keep,
    output logic        out_last,
    output logic        fin,
    output logic        ok,
    output logic        err
);

    state_e      state_q, state_d;
    logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d, chk_q, chk_d;
    logic [15:0] rem_q, rem_d;
    logic [31:0] odata_q, odata_d;
    logic        ovalid_q, ovalid_d, olast_q, olast_d;
    logic [3:0]  okeep_q, okeep_d;
    logic        ok_q, ok_d, err_q, err_d, bad_q, bad_d;
    logic        done_go;
    logic        chk_fail;
    logic [3:0]  pay_keep;
    logic [15:0] take;

    // Bytes of the current payload word that still belong to the datagram.
    always_comb begin
        pay_keep = 4'b0000;
        if (rem_q >= 16'd4) begin
            pay_keep = 4'b1111;
        end else begin
            case (rem_q[1:0])
                2'd3:    pay_keep = 4'b1110;
                2'd2:    pay_keep = 4'b1100;
                2'd1:    pay_keep = 4'b1000;
                default: pay_keep = 4'b0000;
            endcase
        end
    end

    assign take = (rem_q >= 16'd4) ? 16'd4 : rem_q;

`ifdef UDP_CHKSUM_EN
    logic [15:0] sum_q, sum_d, pseudo, acc_base, word_fold, sum_next, chk_eff;
    logic [31:0] acc_data;
    logic        sum_en;

    always_comb begin
        pseudo = ones_add(ones_add(ones_add(in_src_ip[31:16], in_src_ip[15:0]),
                                   ones_add(in_dest_ip[31:16], in_dest_ip[15:0])),
                          {8'h00, IP_PROTO_UDP});
        acc_data = in_data;
        acc_base = sum_q;
        sum_en   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                // Word 0 restarts the accumulator from the pseudo-header.
                acc_base = pseudo;
                sum_en   = in_valid;
            end
            S_HDR1: begin
                // udp_length appears twice: once in the pseudo-header, once in the header.
                acc_base = ones_add(sum_q, in_data[31:16]);
                sum_en   = in_valid;
            end
            S_PAYLOAD: begin
                // Bytes past udp_length are zeroed, which also pads an odd final byte.
                acc_data = in_data & {{8{pay_keep[3]}}, {8{pay_keep[2]}},
                                      {8{pay_keep[1]}}, {8{pay_keep[0]}}};
                sum_en   = in_valid;
            end
            default: sum_en = 1'b0;
        endcase
    end

    ones_comp_add16 u_fold (
        .a_i   (acc_data[31:16]),
        .b_i   (acc_data[15:0]),
        .sum_o (word_fold)
    );

    ones_comp_add16 u_acc (
        .a_i   (acc_base),
        .b_i   (word_fold),
        .sum_o (sum_next)
    );

    assign sum_d    = sum_en ? sum_next : sum_q;
    // The checksum field is still on in_data when HDR1 itself finishes the datagram.
    assign chk_eff  = (state_q == S_HDR1) ? in_data[15:0] : chk_q;
    assign chk_fail = (chk_eff != 16'h0000) && (sum_d != 16'hFFFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sum_q <= 16'h0000;
        else        sum_q <= sum_d;
    end
`else
    logic unused_ip;
    assign unused_ip = &{1'b0, in_src_ip, in_dest_ip};
    assign chk_fail  = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        chk_d    = chk_q;
        rem_d    = rem_q;
        odata_d  = odata_q;
        ovalid_d = 1'b0;
        okeep_d  = 4'b0000;
        olast_d  = 1'b0;
        ok_d     = ok_q;
        err_d    = err_q;
        bad_d    = bad_q;
        done_go  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (in_valid) begin
                    src_d = in_data[31:16];
                    dst_d = in_data[15:0];
                    ok_d  = 1'b0;
                    err_d = 1'b0;
                    bad_d = !in_ok || (in_protocol != IP_PROTO_UDP);
                    if (in_last) begin
                        bad_d   = 1'b1;
                        state_d = S_DONE;
                        done_go = 1'b1;
                    end else if (bad_d) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_HDR1;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_HDR1: begin
                if (in_valid) begin
                    len_d = in_data[31:16];
                    chk_d = in_data[15:0];
                    rem_d = in_data[31:16] - UDP_HDR_BYTES;
                    if (in_last) begin
                        bad_d   = 1'b1;
                        state_d = S_DONE;
                        done_go = 1'b1;
                    end else if ((in_data[31:16] < UDP_HDR_BYTES) || (in_data[31:16] > MAX_LEN)) begin
                        bad_d   = 1'b1;
                        state_d = S_DRAIN;
                    end else if (in_data[31:16] == UDP_HDR_BYTES) begin
                        state_d = S_DONE;
                        done_go = 1'b1;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (in_valid) begin
                    odata_d  = in_data;
                    ovalid_d = 1'b1;
                    okeep_d  = pay_keep;
                    rem_d    = rem_q - take;
                    if (rem_d == 16'd0) begin
                        olast_d = 1'b1;
                        if (in_last) begin
                            state_d = S_DONE;
                            done_go = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else if (in_last) begin
                        olast_d = 1'b1;
                        bad_d   = 1'b1;
                        state_d = S_DONE;
                        done_go = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (in_valid && in_last) begin
                    state_d = S_DONE;
                    done_go = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status is registered on entry to DONE so it lines up with the fin cycle.
        if (done_go) begin
            ok_d  = !(bad_d || chk_fail);
            err_d = bad_d || chk_fail;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            src_q    <= 16'h0000;
            dst_q    <= 16'h0000;
            len_q    <= 16'h0000;
            chk_q    <= 16'h0000;
            rem_q    <= 16'h0000;
            odata_q  <= 32'h0000_0000;
            ovalid_q <= 1'b0;
            okeep_q  <= 4'b0000;
            olast_q  <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            chk_q    <= chk_d;
            rem_q    <= rem_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            okeep_q  <= okeep_d;
            olast_q  <= olast_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            bad_q    <= bad_d;
        end
    end

    assign src_port   = src_q;
    assign dest_port  = dst_q;
    assign udp_length = len_q;
    assign udp_chksum = chk_q;
    assign out_data   = odata_q;
    assign out_valid  = ovalid_q;
    assign out_keep   = okeep_q;
    assign out_last   = olast_q;
    assign fin        = (state_q == S_DONE);
    assign ok         = ok_q;
    assign err        = err_q;

endmodule

// File: tb/tb_udp_decoder.sv
// tb/tb_udp_decoder.sv - directed self-checking bench for udp_decoder
module tb_udp_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ok = 1'b1;
    logic [7:0]  in_protocol = 8'd17;
    logic [31:0] in_src_ip = 32'hC0A8_0001;
    logic [31:0] in_dest_ip = 32'hC0A8_00C7;
    logic [15:0] src_port, dest_port, udp_length, udp_chksum;
    logic [31:0] out_data;
    logic        out_valid, out_last, fin, ok, err;
    logic [3:0]  out_keep;

    int n_cmp = 0;
    int n_bad = 0;
    int cycle = 0;
    int fin_cnt = 0;
    int fin_cycle = 0;
    int last_acc_cycle = 0;
    logic fin_ok = 1'b0;
    logic fin_err = 1'b0;

    logic [31:0] oq_data[$];
    logic [3:0]  oq_keep[$];
    logic        oq_last[$];
    logic [31:0] wq[$];
    logic        lq[$];

    udp_decoder dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ok(in_ok), .in_protocol(in_protocol), .in_src_ip(in_src_ip), .in_dest_ip(in_dest_ip),
        .src_port(src_port), .dest_port(dest_port), .udp_length(udp_length), .udp_chksum(udp_chksum),
        .out_data(out_data), .out_valid(out_valid), .out_keep(out_keep), .out_last(out_last),
        .fin(fin), .ok(ok), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (out_valid) begin
                oq_data.push_back(out_data);
                oq_keep.push_back(out_keep);
                oq_last.push_back(out_last);
            end
            if (fin) begin
                fin_cnt   = fin_cnt + 1;
                fin_ok    = ok;
                fin_err   = err;
                fin_cycle = cycle;
            end
        end
    end

    task automatic clear_q();
        oq_data.delete(); oq_keep.delete(); oq_last.delete();
        wq.delete(); lq.delete();
    endtask

    task automatic add(input logic [31:0] w, input logic l);
        wq.push_back(w);
        lq.push_back(l);
    endtask

    task automatic push_basic(input logic [15:0] chk);
        add(32'h1234_0050, 1'b0);
        add({16'h0013, chk}, 1'b0);
        add(32'h4865_6C6C, 1'b0);
        add(32'h6F20_576F, 1'b0);
        add(32'h726C_6400, 1'b1);
    endtask

    task automatic send(input int gap_at);
        for (int i = 0; i < wq.size(); i++) begin
            if (i == gap_at) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                @(posedge clk); #1;
            end
            in_data  = wq[i];
            in_valid = 1'b1;
            in_last  = lq[i];
            @(posedge clk); #1;
            if (lq[i]) last_acc_cycle = cycle;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        wq.delete();
        lq.delete();
    endtask

    task automatic wait_fin(input int target);
        for (int i = 0; i < 20 && fin_cnt < target; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Independent reference: plain 32-bit sum of all 16-bit words, then folded.
    function automatic logic [15:0] model_chksum();
        logic [31:0] s;
        s = 32'hC0A8 + 32'h0001 + 32'hC0A8 + 32'h00C7 + 32'h0011 + 32'h0013;
        s = s + 32'h1234 + 32'h0050 + 32'h0013 + 32'h0000;
        s = s + 32'h4865 + 32'h6C6C + 32'h6F20 + 32'h576F + 32'h726C + 32'h6400;
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        if (~s[15:0] == 16'h0000) return 16'hFFFF;
        return ~s[15:0];
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({out_valid, out_last, out_keep, fin, ok, err} !== 9'd0 || out_data !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b l=%b k=%b fin=%b ok=%b err=%b d=%h, want all 0",
                     out_valid, out_last, out_keep, fin, ok, err, out_data);
        end
        n_cmp++;
        if ({src_port, dest_port, udp_length, udp_chksum} !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_fields: got %h %h %h %h, want 0", src_port, dest_port, udp_length, udp_chksum);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int base;
        logic [3:0] ek[3];
        logic [31:0] ed[3];
        ek[0] = 4'b1111; ek[1] = 4'b1111; ek[2] = 4'b1110;
        ed[0] = 32'h4865_6C6C; ed[1] = 32'h6F20_576F; ed[2] = 32'h726C_6400;
        clear_q();
        base = fin_cnt;
        push_basic(16'h0000);
        send(3);
        wait_fin(base + 1);
        n_cmp++;
        if (src_port !== 16'h1234 || dest_port !== 16'h0050 || udp_length !== 16'h0013) begin
            n_bad++;
            $display("FAIL basic_hdr: got %h %h %h, want 1234 0050 0013", src_port, dest_port, udp_length);
        end
        n_cmp++;
        if (oq_data.size() != 3) begin
            n_bad++;
            $display("FAIL basic_count: got %0d words, want 3", oq_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (oq_data[i] !== ed[i] || oq_keep[i] !== ek[i] || oq_last[i] !== (i == 2)) begin
                    n_bad++;
                    $display("FAIL basic_word%0d: got %h k=%b l=%b, want %h k=%b l=%b",
                             i, oq_data[i], oq_keep[i], oq_last[i], ed[i], ek[i], i == 2);
                end
            end
        end
        n_cmp++;
        if (fin_cnt !== base + 1 || fin_ok !== 1'b1 || fin_err !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_fin: got fins=%0d ok=%b err=%b, want %0d ok=1 err=0", fin_cnt, fin_ok, fin_err, base + 1);
        end
        n_cmp++;
        if (fin_cycle !== last_acc_cycle) begin
            n_bad++;
            $display("FAIL basic_fin_time: got cycle %0d, want %0d", fin_cycle, last_acc_cycle);
        end
        @(negedge clk);
        n_cmp++;
        if (ok !== 1'b1 || err !== 1'b0 || fin !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_hold: got ok=%b err=%b fin=%b, want ok=1 err=0 fin=0", ok, err, fin);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_padding();
        int base;
        clear_q();
        base = fin_cnt;
        add(32'h0400_0401, 1'b0);
        add(32'h000A_0000, 1'b0);
        add(32'hAABB_CCDD, 1'b0);
        add(32'h1111_2222, 1'b0);
        add(32'h3333_4444, 1'b1);
        send(-1);
        wait_fin(base + 1);
        n_cmp++;
        if (oq_data.size() != 1 || oq_keep[0] !== 4'b1100 || oq_last[0] !== 1'b1 || oq_data[0] !== 32'hAABB_CCDD) begin
            n_bad++;
            $display("FAIL pad_out: got n=%0d k=%b l=%b d=%h, want n=1 k=1100 l=1 d=aabbccdd",
                     oq_data.size(), oq_keep[0], oq_last[0], oq_data[0]);
        end
        n_cmp++;
        if (fin_cnt !== base + 1 || fin_ok !== 1'b1 || fin_err !== 1'b0 || fin_cycle !== last_acc_cycle) begin
            n_bad++;
            $display("FAIL pad_fin: got fins=%0d ok=%b err=%b cyc=%0d, want %0d ok=1 err=0 cyc=%0d",
                     fin_cnt, fin_ok, fin_err, fin_cycle, base + 1, last_acc_cycle);
        end
    endtask

    task automatic test_truncation();
        int base;
        clear_q();
        base = fin_cnt;
        add(32'h0001_0002, 1'b0);
        add(32'h0020_0000, 1'b0);
        add(32'h5555_6666, 1'b1);
        send(-1);
        wait_fin(base + 1);
        n_cmp++;
        if (oq_data.size() != 1 || oq_keep[0] !== 4'b1111 || oq_last[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL trunc_out: got n=%0d k=%b l=%b, want n=1 k=1111 l=1", oq_data.size(), oq_keep[0], oq_last[0]);
        end
        n_cmp++;
        if (fin_cnt !== base + 1 || fin_ok !== 1'b0 || fin_err !== 1'b1) begin
            n_bad++;
            $display("FAIL trunc_fin: got fins=%0d ok=%b err=%b, want %0d ok=0 err=1", fin_cnt, fin_ok, fin_err, base + 1);
        end
    endtask

    task automatic test_bad_header();
        int base;
        logic [15:0] lens[4];
        logic [7:0]  protos[4];
        logic        oks[4];
        lens[0] = 16'h0004; protos[0] = 8'd17; oks[0] = 1'b1;
        lens[1] = 16'h0013; protos[1] = 8'd6;  oks[1] = 1'b1;
        lens[2] = 16'h0013; protos[2] = 8'd17; oks[2] = 1'b0;
        lens[3] = 16'h05C1; protos[3] = 8'd17; oks[3] = 1'b1;
        for (int v = 0; v < 4; v++) begin
            clear_q();
            base = fin_cnt;
            in_protocol = protos[v];
            in_ok = oks[v];
            add(32'h1234_0050, 1'b0);
            add({lens[v], 16'h0000}, 1'b0);
            add(32'h0102_0304, 1'b0);
            add(32'h0506_0708, 1'b1);
            send(-1);
            wait_fin(base + 1);
            n_cmp++;
            if (oq_data.size() != 0 || fin_cnt !== base + 1 || fin_err !== 1'b1 || fin_ok !== 1'b0
                || fin_cycle !== last_acc_cycle) begin
                n_bad++;
                $display("FAIL bad_hdr%0d: got outs=%0d fins=%0d ok=%b err=%b cyc=%0d, want outs=0 fins=%0d ok=0 err=1 cyc=%0d",
                         v, oq_data.size(), fin_cnt, fin_ok, fin_err, fin_cycle, base + 1, last_acc_cycle);
            end
        end
        in_protocol = 8'd17;
        in_ok = 1'b1;
    endtask

    task automatic test_reset_abort();
        int base;
        clear_q();
        base = fin_cnt;
        add(32'h1234_0050, 1'b0);
        add(32'h0013_0000, 1'b0);
        add(32'h4865_6C6C, 1'b0);
        send(-1);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, out_last, fin, ok, err} !== 5'd0 || src_port !== 16'd0 || udp_length !== 16'd0) begin
            n_bad++;
            $display("FAIL abort_reset: got v=%b l=%b fin=%b ok=%b err=%b sp=%h len=%h, want all 0",
                     out_valid, out_last, fin, ok, err, src_port, udp_length);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        clear_q();
        push_basic(16'h0000);
        send(-1);
        wait_fin(base + 1);
        n_cmp++;
        if (fin_cnt !== base + 1 || fin_ok !== 1'b1 || oq_data.size() != 3) begin
            n_bad++;
            $display("FAIL abort_next: got fins=%0d ok=%b outs=%0d, want fins=%0d ok=1 outs=3",
                     fin_cnt, fin_ok, oq_data.size(), base + 1);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        clear_q();
        base = fin_cnt;
        push_basic(16'h0000);
        add(32'h0400_0401, 1'b0);
        add(32'h000C_0000, 1'b0);
        add(32'hDEAD_BEEF, 1'b1);
        send(-1);
        wait_fin(base + 2);
        n_cmp++;
        if (fin_cnt !== base + 2 || fin_ok !== 1'b1 || oq_data.size() != 4 || src_port !== 16'h0400) begin
            n_bad++;
            $display("FAIL b2b: got fins=%0d ok=%b outs=%0d sp=%h, want fins=%0d ok=1 outs=4 sp=0400",
                     fin_cnt, fin_ok, oq_data.size(), src_port, base + 2);
        end
        n_cmp++;
        if (oq_data.size() == 4 && (oq_data[3] !== 32'hDEAD_BEEF || oq_keep[3] !== 4'b1111 || oq_last[3] !== 1'b1)) begin
            n_bad++;
            $display("FAIL b2b_word: got %h k=%b l=%b, want deadbeef k=1111 l=1", oq_data[3], oq_keep[3], oq_last[3]);
        end
    endtask

    task automatic test_checksum();
        int base;
        logic [15:0] good;
        logic [15:0] chks[3];
        logic        want_ok[3];
        good = model_chksum();
`ifdef UDP_CHKSUM_EN
        chks[0] = good;            want_ok[0] = 1'b1;
        chks[1] = good ^ 16'h0001; want_ok[1] = 1'b0;
        chks[2] = 16'h0000;        want_ok[2] = 1'b1;
`else
        chks[0] = good;            want_ok[0] = 1'b1;
        chks[1] = good ^ 16'h0001; want_ok[1] = 1'b1;
        chks[2] = 16'hBEEF;        want_ok[2] = 1'b1;
`endif
        for (int v = 0; v < 3; v++) begin
            clear_q();
            base = fin_cnt;
            push_basic(chks[v]);
            send(-1);
            wait_fin(base + 1);
            n_cmp++;
            if (fin_cnt !== base + 1 || fin_ok !== want_ok[v] || fin_err !== !want_ok[v] || udp_chksum !== chks[v]) begin
                n_bad++;
                $display("FAIL chksum%0d: got fins=%0d ok=%b err=%b chk=%h, want fins=%0d ok=%b err=%b chk=%h",
                         v, fin_cnt, fin_ok, fin_err, udp_chksum, base + 1, want_ok[v], !want_ok[v], chks[v]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_padding();
        test_truncation();
        test_bad_header();
        test_reset_abort();
        test_back_to_back();
        test_checksum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
